// File: rtl/cmplx_mult_pipe.sv
// rtl/cmplx_mult_pipe.sv - 3-stage pipelined complex multiplier with valid/ready, optional conj(tw)
// Optional ROUND_SAT_EN: round half-up and saturate instead of truncate and wrap.
module cmplx_mult_pipe #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter int OW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  input  logic [TW-1:0]   tw_re,
  input  logic [TW-1:0]   tw_im,
  input  logic            in_conj,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*OW-1:0] out_data
);

  localparam int PW = DW + TW;
  localparam int CW = PW + 1;
  localparam int HI = TW + OW - 2;
  localparam int LO = TW - 1;

  logic en;
  logic valid1, valid2;

  logic signed [DW-1:0] a_re, a_im;
  logic signed [TW-1:0] b_re, b_im;
  logic                 conj1, conj2;

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

  logic signed [CW-1:0] e_rr, e_ii, e_ri, e_ir;
  logic signed [CW-1:0] c_re, c_im;
  logic [CW-1:0]        r_re, r_im;
  logic [OW-1:0]        s_re, s_im;
  logic                 unused_bits;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1    <= 1'b0;
      valid2    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      valid1    <= in_valid;
      valid2    <= valid1;
      out_valid <= valid2;
      if (valid2) begin
        out_data <= {s_im, s_re};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a_re  <= in_re;
      a_im  <= in_im;
      b_re  <= tw_re;
      b_im  <= tw_im;
      conj1 <= in_conj;
      p_rr  <= PW'(a_re) * PW'(b_re);
      p_ii  <= PW'(a_im) * PW'(b_im);
      p_ri  <= PW'(a_re) * PW'(b_im);
      p_ir  <= PW'(a_im) * PW'(b_re);
      conj2 <= conj1;
    end
  end

  assign e_rr = CW'(p_rr);
  assign e_ii = CW'(p_ii);
  assign e_ri = CW'(p_ri);
  assign e_ir = CW'(p_ir);

  // Conjugating tw only flips the sign of every term that carries tw_im.
  always_comb begin
    c_re = '0;
    c_im = '0;
    if (conj2) begin
      c_re = e_rr + e_ii;
      c_im = e_ir - e_ri;
    end else begin
      c_re = e_rr - e_ii;
      c_im = e_ri + e_ir;
    end
  end

`ifdef ROUND_SAT_EN
  localparam logic [CW-1:0] RND = CW'(1) << (TW - 2);

  logic ok_re, ok_im;

  assign r_re  = c_re + RND;
  assign r_im  = c_im + RND;
  // Result fits when everything above the kept field is a sign extension.
  assign ok_re = (&r_re[CW-1:HI]) | ~(|r_re[CW-1:HI]);
  assign ok_im = (&r_im[CW-1:HI]) | ~(|r_im[CW-1:HI]);
  assign s_re  = ok_re ? r_re[HI:LO] :
                 (r_re[CW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
  assign s_im  = ok_im ? r_im[HI:LO] :
                 (r_im[CW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}});
  assign unused_bits = ^{r_re[LO-1:0], r_im[LO-1:0]};
`else
  assign r_re = c_re;
  assign r_im = c_im;
  assign s_re = r_re[HI:LO];
  assign s_im = r_im[HI:LO];
  assign unused_bits = ^{r_re[CW-1:HI+1], r_re[LO-1:0], r_im[CW-1:HI+1], r_im[LO-1:0]};
`endif

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// tb/tb_cmplx_mult_pipe.sv - directed self-checking bench for cmplx_mult_pipe
module tb_cmplx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re, in_im, tw_re, tw_im;
  logic        in_conj;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int tests_run    = 0;
  int tests_failed = 0;

  cmplx_mult_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .tw_re     (tw_re),
    .tw_im     (tw_im),
    .in_conj   (in_conj),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] ar, ai, br, bi, input logic cj);
    in_re   = ar;
    in_im   = ai;
    tw_re   = br;
    tw_im   = bi;
    in_conj = cj;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_one(input string tag, input logic [15:0] ar, ai, br, bi,
                        input logic cj, input logic [31:0] exp);
    set_in(ar, ai, br, bi, cj);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_lat3"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp);
    @(posedge clk); #1;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_s [8];
    logic [31:0] held;
    logic        holding;
    logic        fire_in;
    int          si;
    int          so;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_in(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    do_one("t1_half_sq", 16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h0000_2000);
    do_one("t2_j_sq", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0, 32'h0000_E000);
    do_one("t2_j_conj", 16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b1, 32'h0000_2000);
`ifdef ROUND_SAT_EN
    do_one("t3_min_sq", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 32'h7FFF_0000);
    do_one("t4_round", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h0000_0001);
`else
    do_one("t3_min_sq", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 32'h0000_0000);
    do_one("t4_trunc", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 1'b0, 32'h0000_0000);
`endif
    do_one("mix_a", 16'h2000, 16'h1000, 16'h4000, 16'h2000, 1'b0, 32'h1000_0C00);
    do_one("mix_a_conj", 16'h2000, 16'h1000, 16'h4000, 16'h2000, 1'b1, 32'h0000_1400);
    do_one("mix_b", 16'h2000, 16'h1000, 16'h2000, 16'h4000, 1'b0, 32'h1400_0000);
    do_one("mix_b_conj", 16'h2000, 16'h1000, 16'h2000, 16'h4000, 1'b1, 32'hF400_1000);

    // Stream of 8: re = k*0x0800, im = k*0x0100, tw = 0.5 -> {k*0x0080, k*0x0400}
    for (int k = 0; k < 8; k++) begin
      exp_s[k] = {16'((k + 1) * 16'h0080), 16'((k + 1) * 16'h0400)};
    end
    si      = 0;
    so      = 0;
    holding = 1'b0;
    for (int c = 0; c < 40 && so < 8; c++) begin
      in_valid = (si < 8);
      set_in(16'((si + 1) * 16'h0800), 16'((si + 1) * 16'h0100), 16'h4000, 16'h0000, 1'b0);
      out_ready = !(c >= 5 && c < 10);
      #1;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (holding) check("stall_hold", out_data, held);
        held    = out_data;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("stream_data", out_data, exp_s[so]);
        so++;
      end
      fire_in = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire_in) si++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_in_count", 32'(si), 32'd8);
    check("stream_out_count", 32'(so), 32'd8);
    #1;
    check("stream_no_dup", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Two samples in flight, then asynchronous reset.
    set_in(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(16'h0000, 16'h4000, 16'h0000, 16'h4000, 1'b0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_data", out_data, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rst_flush", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    do_one("post_rst", 16'h2000, 16'h1000, 16'h4000, 16'h2000, 1'b0, 32'h1000_0C00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
